// File: rtl/jk_fsm_pkg.sv
// Shared types for the JK-style Moore flag FSM.
// Exports: state_t (OFF/ON encoding) and the reset state ST_RESET.
package jk_fsm_pkg;

   typedef enum logic [0:0] {
      ST_OFF = 1'b0,
      ST_ON  = 1'b1
   } state_t;

   localparam state_t ST_RESET = ST_OFF;

endpackage : jk_fsm_pkg

// File: rtl/jk_moore_fsm.sv
// Two-state Moore FSM with JK semantics: j sets, k clears, j&k toggles.
// Ports: clk, areset_n (async, active-low), j (set), k (clear), out (state==ON).
module jk_moore_fsm
   import jk_fsm_pkg::*;
(
   input  logic clk,
   input  logic areset_n,
   input  logic j,
   input  logic k,
   output logic out
);

   state_t state_q;
   state_t state_d;

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         state_q <= ST_RESET;
      end else begin
         state_q <= state_d;
      end
   end

   // OFF only looks at j, ON only looks at k; j=k=1 therefore toggles.
   always_comb begin
      state_d = ST_RESET;
      case (state_q)
         ST_OFF:  state_d = j ? ST_ON  : ST_OFF;
         ST_ON:   state_d = k ? ST_OFF : ST_ON;
         default: state_d = ST_RESET;
      endcase
   end

   assign out = (state_q == ST_ON);

endmodule : jk_moore_fsm

// File: tb/tb_jk_moore_fsm.sv
// Directed and randomized checks of jk_moore_fsm against a JK reference.
// Inputs change on negedge; out is sampled 1 time unit after each edge.
module tb_jk_moore_fsm;

   logic clk;
   logic areset_n;
   logic j;
   logic k;
   logic out;

   int total;
   int bad;

   jk_moore_fsm dut (
      .clk      (clk),
      .areset_n (areset_n),
      .j        (j),
      .k        (k),
      .out      (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic kv, input logic jv);
      @(negedge clk);
      k = kv;
      j = jv;
      @(posedge clk);
      #1;
   endtask

   // JK characteristic equation: Q+ = J.~Q | ~K.Q
   function automatic logic jk_next(input logic q, input logic jv,
                                    input logic kv);
      return (jv & ~q) | (~kv & q);
   endfunction

   logic [1:0] seq_kj [12];
   logic       seq_out [12];
   logic       m;
   logic       rst_v;

   initial begin
      total = 0;
      bad = 0;
      j = 1'b0;
      k = 1'b0;
      areset_n = 1'b1;
      #2;
      areset_n = 1'b0;

      // Reset hold
      #1;
      check("reset_immediate", out, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("reset_hold", out, 1'b0);

      // Release with j=1 at the first live edge
      @(negedge clk);
      areset_n = 1'b1;
      j = 1'b1;
      @(posedge clk);
      #1;
      check("release_set", out, 1'b1);
      drive(1'b0, 1'b0);
      check("set_hold", out, 1'b1);

      // Async reset from ON, mid-cycle
      @(negedge clk);
      areset_n = 1'b0;
      #1;
      check("async_drop", out, 1'b0);
      @(posedge clk);
      #1;
      check("async_low_c1", out, 1'b0);
      @(posedge clk);
      #1;
      check("async_low_c2", out, 1'b0);
      @(negedge clk);
      areset_n = 1'b1;
      j = 1'b0;
      @(posedge clk);
      #1;
      check("release_idle", out, 1'b0);

      // Transition table, {k,j} per cycle
      seq_kj = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10,
                 2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
      seq_out = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 12; i++) begin
         drive(seq_kj[i][1], seq_kj[i][0]);
         check($sformatf("seq_%0d", i), out, seq_out[i]);
      end

      // Ignored inputs
      drive(1'b1, 1'b0);
      check("clear_from_on", out, 1'b0);
      drive(1'b1, 1'b0);
      check("k_ignored_off", out, 1'b0);
      drive(1'b0, 1'b1);
      check("set_from_off", out, 1'b1);
      drive(1'b0, 1'b1);
      check("j_ignored_on", out, 1'b1);

      // Random soak, checked on both edges
      m = out === 1'b1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         j = 1'($urandom_range(0, 1));
         k = 1'($urandom_range(0, 1));
         rst_v = ($urandom_range(0, 7) != 0);
         areset_n = rst_v;
         if (!rst_v) m = 1'b0;
         #1;
         check($sformatf("soak_neg_%0d", c), out, m);
         @(posedge clk);
         if (areset_n) m = jk_next(m, j, k);
         #1;
         check($sformatf("soak_pos_%0d", c), out, m);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_jk_moore_fsm
